fast_inv_sqrt_arbiter: RTL and testbench

Shares one fastInvSqrt core between NUM_REQ requesters inside the Madgwick filter. Typical requesters are accel norm, mag norm, quaternion norm and the gradient-step norm. Requesters are granted round-robin and one transaction is in flight at a time. The block drives the core's valid/ready handshakes and its local reset. It short-circuits zero operands and recovers from a hung core with a timeout, a core reset and an error response.

---
 rtl/fast_inv_sqrt_arbiter_pkg.sv | 21 ++
 rtl/fast_inv_sqrt_arbiter_if.sv | 48 ++++
 rtl/fast_inv_sqrt_arbiter_rr.sv | 37 +++
 rtl/fast_inv_sqrt_arbiter.sv | 165 ++++++++++++++++
 tb/tb_fast_inv_sqrt_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fast_inv_sqrt_arbiter_pkg.sv
// Shared types and constants for the fastInvSqrt arbiter slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fast_inv_sqrt_pkg;

   localparam int DATA_W_DEF = 16;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_RESP,
      ST_FLUSH
   } state_t;

   // Result returned for a zero operand (saturated) and for an aborted core.
   // Both are single-bit patterns replicated to the instance width.
   localparam logic [DATA_W_DEF-1:0] ZERO_RESULT    = '1;
   localparam logic [DATA_W_DEF-1:0] TIMEOUT_RESULT = '0;

endpackage

// File: rtl/fast_inv_sqrt_arbiter_if.sv
// Handshake bundles: requester side and fastInvSqrt core side.
// Latency: n/a (wires only).
// Backpressure: valid/ready on every channel.

// Requester bundle. master = requesters, slave = arbiter.
interface fisq_req_if #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = fast_inv_sqrt_pkg::DATA_W_DEF
);
   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ-1:0]        req_ready;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic [NUM_REQ-1:0]        rsp_valid;
   logic [NUM_REQ-1:0]        rsp_ready;
   logic [DATA_W-1:0]         rsp_data;
   logic                      rsp_err;

   modport master (
      output req_valid, req_data, rsp_ready,
      input  req_ready, rsp_valid, rsp_data, rsp_err
   );
   modport slave (
      input  req_valid, req_data, rsp_ready,
      output req_ready, rsp_valid, rsp_data, rsp_err
   );
endinterface

// Core bundle. master = arbiter, slave = fastInvSqrt core.
interface fisq_core_if #(
   parameter int DATA_W = fast_inv_sqrt_pkg::DATA_W_DEF
);
   logic              core_rst;
   logic [DATA_W-1:0] core_data_in;
   logic              core_valid_in;
   logic              core_ready_in;
   logic [DATA_W-1:0] core_data_out;
   logic              core_valid_out;
   logic              core_ready_out;

   modport master (
      output core_rst, core_data_in, core_valid_in, core_ready_out,
      input  core_ready_in, core_data_out, core_valid_out
   );
   modport slave (
      input  core_rst, core_data_in, core_valid_in, core_ready_out,
      output core_ready_in, core_data_out, core_valid_out
   );
endinterface

// File: rtl/fast_inv_sqrt_arbiter_rr.sv
// Round-robin pick: first set request searching upward from ptr+1 (wrapping).
// Latency: combinational.
// Backpressure: none; en_i low forces an empty grant.
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int IDW     = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDW-1:0]     ptr_i,
   input  logic               en_i,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic [IDW-1:0]     idx_o,
   output logic               vld_o
);

   // Scan NUM_REQ positions after the pointer; the first hit wins.
   always_comb begin
      int j;
      logic [IDW-1:0] k;
      gnt_o = '0;
      idx_o = '0;
      vld_o = 1'b0;
      j     = 0;
      k     = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         j = int'(ptr_i) + i;
         if (j >= NUM_REQ) j = j - NUM_REQ;
         k = IDW'(j);
         if (en_i && !vld_o && req_i[k]) begin
            vld_o    = 1'b1;
            idx_o    = k;
            gnt_o[k] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fast_inv_sqrt_arbiter.sv
// Shares one fastInvSqrt core among NUM_REQ requesters, one transaction at a time.
// Latency: accept c0, issue c1, response at 1+L+1 for core latency L; zero operand answers at c1.
// Backpressure: req_ready only in IDLE; operand and response held until their ready; hung core aborted after TIMEOUT.
module fast_inv_sqrt_arbiter
   import fast_inv_sqrt_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int DATA_W    = DATA_W_DEF,
   parameter int TIMEOUT   = 255,
   parameter int RST_PULSE = 2,
   localparam int IDW      = $clog2(NUM_REQ)
) (
   input  logic             clk,
   input  logic             rst,
   fisq_req_if.slave        req,
   fisq_core_if.master      core,
   output logic             busy,
   output logic [IDW-1:0]   grant_id
);

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int PW = $clog2(RST_PULSE + 1);
   localparam logic [DATA_W-1:0] ZERO_RES = {DATA_W{ZERO_RESULT[0]}};
   localparam logic [DATA_W-1:0] TMO_RES  = {DATA_W{TIMEOUT_RESULT[0]}};

   state_t              state_q;
   logic [IDW-1:0]      rr_ptr_q;
   logic [IDW-1:0]      grant_q;
   logic [DATA_W-1:0]   op_q;
   logic [DATA_W-1:0]   rsp_data_q;
   logic                rsp_err_q;
   logic [NUM_REQ-1:0]  rsp_vld_q;
   logic                core_vld_q;
   logic                core_rdy_q;
   logic                flush_q;
   logic [TW-1:0]       tmo_q;
   logic [PW-1:0]       pls_q;

   logic [NUM_REQ-1:0]  arb_gnt;
   logic [IDW-1:0]      arb_idx;
   logic                arb_vld;
   logic [DATA_W-1:0]   win_dat;
   logic [NUM_REQ-1:0]  gnt_oh;
   logic                tmo_hit;
   logic                rsp_hs;

   // Grants only from IDLE and never while reset is held, so req_ready is 0 in reset.
   rr_arbiter #(.NUM_REQ(NUM_REQ), .IDW(IDW)) u_rr (
      .req_i (req.req_valid),
      .ptr_i (rr_ptr_q),
      .en_i  ((state_q == ST_IDLE) && !rst),
      .gnt_o (arb_gnt),
      .idx_o (arb_idx),
      .vld_o (arb_vld)
   );

   assign win_dat = req.req_data[arb_idx*DATA_W +: DATA_W];
   assign gnt_oh  = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_q;
   // >= because a handshake on the last allowed cycle carries the count past the limit.
   assign tmo_hit = (tmo_q >= TW'(TIMEOUT - 1));
   assign rsp_hs  = |(rsp_vld_q & req.rsp_ready);

   // Transaction FSM: all state and outputs registered here.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         rr_ptr_q   <= IDW'(NUM_REQ - 1);
         grant_q    <= '0;
         op_q       <= '0;
         rsp_data_q <= '0;
         rsp_err_q  <= 1'b0;
         rsp_vld_q  <= '0;
         core_vld_q <= 1'b0;
         core_rdy_q <= 1'b0;
         flush_q    <= 1'b0;
         tmo_q      <= '0;
         pls_q      <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (arb_vld) begin
                  grant_q <= arb_idx;
                  op_q    <= win_dat;
                  if (win_dat == '0) begin
                     // Zero has no inverse square root: answer saturated, leave the core alone.
                     rsp_data_q <= ZERO_RES;
                     rsp_err_q  <= 1'b1;
                     rsp_vld_q  <= arb_gnt;
                     state_q    <= ST_RESP;
                  end else begin
                     tmo_q      <= '0;
                     core_vld_q <= 1'b1;
                     state_q    <= ST_ISSUE;
                  end
               end
            end
            ST_ISSUE: begin
               if (core.core_ready_in) begin
                  core_vld_q <= 1'b0;
                  core_rdy_q <= 1'b1;
                  tmo_q      <= tmo_q + 1'b1;
                  state_q    <= ST_WAIT;
               end else if (tmo_hit) begin
                  core_vld_q <= 1'b0;
                  flush_q    <= 1'b1;
                  pls_q      <= '0;
                  rsp_data_q <= TMO_RES;
                  rsp_err_q  <= 1'b1;
                  state_q    <= ST_FLUSH;
               end else begin
                  tmo_q <= tmo_q + 1'b1;
               end
            end
            ST_WAIT: begin
               if (core.core_valid_out) begin
                  rsp_data_q <= core.core_data_out;
                  rsp_err_q  <= 1'b0;
                  core_rdy_q <= 1'b0;
                  rsp_vld_q  <= gnt_oh;
                  state_q    <= ST_RESP;
               end else if (tmo_hit) begin
                  core_rdy_q <= 1'b0;
                  flush_q    <= 1'b1;
                  pls_q      <= '0;
                  rsp_data_q <= TMO_RES;
                  rsp_err_q  <= 1'b1;
                  state_q    <= ST_FLUSH;
               end else begin
                  tmo_q <= tmo_q + 1'b1;
               end
            end
            ST_FLUSH: begin
               if (pls_q == PW'(RST_PULSE - 1)) begin
                  flush_q   <= 1'b0;
                  rsp_vld_q <= gnt_oh;
                  state_q   <= ST_RESP;
               end else begin
                  pls_q <= pls_q + 1'b1;
               end
            end
            ST_RESP: begin
               if (rsp_hs) begin
                  rsp_vld_q <= '0;
                  rr_ptr_q  <= grant_q;
                  state_q   <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign req.req_ready      = arb_gnt;
   assign req.rsp_valid      = rsp_vld_q;
   assign req.rsp_data       = rsp_data_q;
   assign req.rsp_err        = rsp_err_q;
   // The core is cleared with the arbiter as well as by the abort pulse.
   assign core.core_rst       = rst | flush_q;
   assign core.core_data_in   = op_q;
   assign core.core_valid_in  = core_vld_q;
   assign core.core_ready_out = core_rdy_q;
   assign busy                = (state_q != ST_IDLE);
   assign grant_id            = grant_q;

endmodule

// File: tb/tb_fast_inv_sqrt_arbiter.sv
// Bench for fast_inv_sqrt_arbiter with a behavioural fastInvSqrt core.
// Latency: core answers LAT cycles after accept; result = operand ^ 0x1634.
// Backpressure: core_ready_in and rsp_ready stalled on demand.
module tb_fast_inv_sqrt_arbiter;

   localparam int NR  = 4;
   localparam int DW  = 16;
   localparam int LAT = 5;

   typedef struct packed {
      logic [3:0]    idx;
      logic [DW-1:0] dat;
      logic          err;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic busy;
   logic [1:0] grant_id;

   fisq_req_if  #(.NUM_REQ(NR), .DATA_W(DW)) u_req ();
   fisq_core_if #(.DATA_W(DW))               u_core ();

   fast_inv_sqrt_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .TIMEOUT(20), .RST_PULSE(2)) dut (
      .clk      (clk),
      .rst      (rst),
      .req      (u_req),
      .core     (u_core),
      .busy     (busy),
      .grant_id (grant_id)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Behavioural core
   logic          hang = 1'b0;
   logic          core_stall = 1'b0;
   logic          pend;
   int            ccnt;
   logic [DW-1:0] cop;

   assign u_core.core_ready_in  = !core_stall;
   assign u_core.core_valid_out = pend && (ccnt == 0) && !hang;
   assign u_core.core_data_out  = u_core.core_valid_out ? (cop ^ 16'h1634) : 16'h0;

   always @(posedge clk or posedge u_core.core_rst) begin
      if (u_core.core_rst) begin
         pend <= 1'b0;
         ccnt <= 0;
         cop  <= '0;
      end else if (u_core.core_valid_in && u_core.core_ready_in) begin
         pend <= 1'b1;
         ccnt <= LAT - 1;
         cop  <= u_core.core_data_in;
      end else if (pend && ccnt > 0) begin
         ccnt <= ccnt - 1;
      end else if (u_core.core_valid_out && u_core.core_ready_out) begin
         pend <= 1'b0;
      end
   end

   // Scoreboard and monitors
   exp_t          sb[$];
   int            glog[$];
   logic [DW-1:0] seen[$];
   int cyc = 0, t_acc = 0, last_lat = 0;
   int cv_cyc = 0, rv_cyc = 0, n_core_acc = 0, n_rsp_hs = 0;
   int rpl = 0, last_pulse = 0;
   logic prev_rv = 1'b0;

   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         rpl     = 0;
         prev_rv = 1'b0;
      end else begin
         if (u_core.core_valid_in) cv_cyc++;
         if (u_core.core_valid_in && u_core.core_ready_in) begin
            n_core_acc++;
            seen.push_back(u_core.core_data_in);
         end
         if (u_core.core_rst) rpl++;
         else if (rpl != 0) begin
            last_pulse = rpl;
            rpl = 0;
         end
         if (|(u_req.req_valid & u_req.req_ready)) t_acc = cyc;
         if ((|u_req.rsp_valid) && !prev_rv) last_lat = cyc - t_acc;
         prev_rv = |u_req.rsp_valid;
         if (|u_req.rsp_valid) rv_cyc++;
         if (|(u_req.rsp_valid & u_req.rsp_ready)) begin
            int idx;
            exp_t e;
            idx = 0;
            for (int i = 0; i < NR; i++) if (u_req.rsp_valid[i]) idx = i;
            n_rsp_hs++;
            chk("rsp_onehot", 32'($onehot(u_req.rsp_valid)), 32'd1);
            if (sb.size() == 0) begin
               chk("rsp_unexpected", 32'd1, 32'd0);
            end else begin
               e = sb.pop_front();
               chk("rsp_idx", idx, 32'(e.idx));
               chk("rsp_grant_id", 32'(grant_id), 32'(e.idx));
               chk("rsp_data", 32'(u_req.rsp_data), 32'(e.dat));
               chk("rsp_err", 32'(u_req.rsp_err), 32'(e.err));
            end
         end
      end
   end

   task automatic send(input int idx, input logic [DW-1:0] dat);
      exp_t e;
      logic got;
      @(posedge clk); #1;
      u_req.req_valid[idx]          = 1'b1;
      u_req.req_data[idx*DW +: DW] = dat;
      got = 1'b0;
      for (int n = 0; n < 2000 && !got; n++) begin
         @(negedge clk);
         got = u_req.req_ready[idx];
      end
      if (!got) begin
         chk($sformatf("grant_wait%0d", idx), 32'd0, 32'd1);
      end else begin
         glog.push_back(idx);
         e.idx = 4'(idx);
         e.err = (dat == '0) || hang;
         e.dat = (dat == '0) ? 16'hFFFF : (hang ? 16'h0000 : (dat ^ 16'h1634));
         sb.push_back(e);
      end
      @(posedge clk); #1;
      u_req.req_valid[idx] = 1'b0;
   endtask

   task automatic wait_idle();
      logic ok;
      ok = 1'b0;
      for (int n = 0; n < 1000 && !ok; n++) begin
         @(negedge clk);
         ok = (sb.size() == 0) && !busy;
      end
      if (!ok) begin
         chk("idle_wait", 32'd0, 32'd1);
         sb.delete();
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      sb.delete();
      glog.delete();
   endtask

   task automatic wait_sig(input string tag, input int which);
      logic ok;
      ok = 1'b0;
      for (int n = 0; n < 200 && !ok; n++) begin
         @(negedge clk);
         case (which)
            0: ok = u_core.core_valid_in;
            1: ok = u_req.rsp_valid[1];
            default: ok = u_core.core_ready_out;
         endcase
      end
      if (!ok) chk(tag, 32'd0, 32'd1);
   endtask

   task automatic chk_outputs_zero(input string pfx);
      chk({pfx, "_busy"},     32'(busy), 32'd0);
      chk({pfx, "_grant"},    32'(grant_id), 32'd0);
      chk({pfx, "_req_rdy"},  32'(u_req.req_ready), 32'd0);
      chk({pfx, "_rsp_vld"},  32'(u_req.rsp_valid), 32'd0);
      chk({pfx, "_rsp_dat"},  32'(u_req.rsp_data), 32'd0);
      chk({pfx, "_rsp_err"},  32'(u_req.rsp_err), 32'd0);
      chk({pfx, "_cvi"},      32'(u_core.core_valid_in), 32'd0);
      chk({pfx, "_cdi"},      32'(u_core.core_data_in), 32'd0);
      chk({pfx, "_cro"},      32'(u_core.core_ready_out), 32'd0);
      chk({pfx, "_core_rst"}, 32'(u_core.core_rst), 32'd1);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [DW-1:0] d0, rd;
      logic          re;
      int            b0, b1, b2;

      u_req.req_valid = '0;
      u_req.req_data  = '0;
      u_req.rsp_ready = '1;
      repeat (2) @(negedge clk);
      chk_outputs_zero("reset");
      rst = 1'b0;
      @(negedge clk);
      chk("post_reset_core_rst", 32'(u_core.core_rst), 32'd0);

      // Single request, nominal latency
      seen.delete();
      send(1, 16'h0400);
      wait_idle();
      chk("t1_core_din", (seen.size() > 0) ? 32'(seen[0]) : 32'hDEAD, 32'h0400);
      chk("t1_latency", last_lat, 1 + LAT + 1);

      // Round robin with everyone requesting
      do_reset();
      fork
         begin for (int k = 0; k < 2; k++) send(0, 16'h0100 + 16'(k)); end
         begin for (int k = 0; k < 2; k++) send(1, 16'h0200 + 16'(k)); end
         begin for (int k = 0; k < 2; k++) send(2, 16'h0300 + 16'(k)); end
         begin for (int k = 0; k < 2; k++) send(3, 16'h0400 + 16'(k)); end
      join
      wait_idle();
      chk("rr_count", glog.size(), 8);
      for (int k = 0; k < 8; k++)
         chk($sformatf("rr_order%0d", k), (k < glog.size()) ? glog[k] : 99, k % NR);

      // Zero operand short-circuit
      b0 = cv_cyc;
      send(2, 16'h0000);
      wait_idle();
      chk("zero_no_core", cv_cyc - b0, 0);

      // Hung core: timeout, core reset pulse, error response, then recovery
      hang = 1'b1;
      last_pulse = 0;
      send(0, 16'h0555);
      wait_idle();
      chk("tmo_pulse_len", last_pulse, 2);
      hang = 1'b0;
      send(3, 16'h0777);
      wait_idle();

      // Backpressure on core input and on response
      u_req.rsp_ready = '0;
      core_stall = 1'b1;
      b0 = n_core_acc;
      b1 = n_rsp_hs;
      fork send(1, 16'h0A0A); join_none
      wait_sig("bp_wait_cvi", 0);
      d0 = u_core.core_data_in;
      chk("bp_cdi_val", 32'(d0), 32'h0A0A);
      repeat (3) begin
         @(negedge clk);
         chk("bp_cvi_hold", 32'(u_core.core_valid_in), 32'd1);
         chk("bp_cdi_hold", 32'(u_core.core_data_in), 32'(d0));
      end
      @(posedge clk); #1;
      core_stall = 1'b0;
      wait_sig("bp_wait_rsp", 1);
      rd = u_req.rsp_data;
      re = u_req.rsp_err;
      repeat (4) begin
         @(negedge clk);
         chk("bp_rsp_vld_hold", 32'(u_req.rsp_valid[1]), 32'd1);
         chk("bp_rsp_dat_hold", 32'(u_req.rsp_data), 32'(rd));
         chk("bp_rsp_err_hold", 32'(u_req.rsp_err), 32'(re));
      end
      @(posedge clk); #1;
      u_req.rsp_ready = '1;
      wait_idle();
      chk("bp_core_hs", n_core_acc - b0, 1);
      chk("bp_rsp_hs", n_rsp_hs - b1, 1);

      // Asynchronous reset while waiting on the core
      fork send(2, 16'h0321); join_none
      wait_sig("rst_wait_wait", 2);
      #1;
      rst = 1'b1;
      #1;
      chk_outputs_zero("midrst");
      sb.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      b2 = rv_cyc;
      repeat (12) @(negedge clk);
      chk("midrst_no_rsp", rv_cyc - b2, 0);
      glog.delete();
      fork
         send(3, 16'h0033);
         send(0, 16'h0011);
      join
      wait_idle();
      wait_idle();
      chk("midrst_first", (glog.size() > 0) ? glog[0] : 99, 0);
      chk("midrst_second", (glog.size() > 1) ? glog[1] : 99, 3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
